// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer: retire/dispatch/CDB payloads,
// per-entry storage layout and a 3-bit popcount helper.
package rob_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned ROB_SZ    = 32;
   localparam int unsigned RT_W      = 3;
   localparam int unsigned ROB_TAG_W = $clog2(ROB_SZ);
   localparam int unsigned ROB_CNT_W = ROB_TAG_W + 1;
   localparam int unsigned REG_IDX_W = 5;

   localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic [REG_IDX_W-1:0] dest_reg_idx;
      logic [ROB_TAG_W-1:0] tag;
      logic [XLEN-1:0]      value;
      logic                 valid;
      logic                 take_branch;
      logic                 halt;
      logic [XLEN-1:0]      NPC;
   } ROB_RT_PACKET;

   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] dest_reg_idx;
      logic [XLEN-1:0]      NPC;
      logic                 halt;
   } DP_ROB_PACKET;

   typedef struct packed {
      logic                 valid;
      logic [ROB_TAG_W-1:0] tag;
      logic [XLEN-1:0]      value;
      logic                 take_branch;
   } CDB_PACKET;

   typedef struct packed {
      logic [REG_IDX_W-1:0] dest_reg_idx;
      logic [XLEN-1:0]      NPC;
      logic                 halt;
      logic [XLEN-1:0]      value;
      logic                 take_branch;
      logic                 complete;
   } rob_entry_t;

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
   endfunction

endpackage

// File: rtl/rob_retire_window.sv
// Combinational retire window: selects up to three oldest completed entries,
// closing after the first taken-branch or halt. ROB_CDB_BYPASS_EN forwards the CDB.
module rob_retire_window
   import rob_pkg::*;
(
   input  logic [ROB_TAG_W-1:0]       head,
   input  logic [ROB_CNT_W-1:0]       count,
   input  rob_entry_t [RT_W-1:0]      head_entries,
`ifdef ROB_CDB_BYPASS_EN
   input  CDB_PACKET [RT_W-1:0]       cdb,
`endif
   output ROB_RT_PACKET [RT_W-1:0]    packets,
   output logic [1:0]                 pop_cnt
);

   logic [RT_W-1:0][ROB_TAG_W-1:0] idx;
   logic [RT_W-1:0]                done;
   logic [RT_W-1:0]                brn;
   logic [RT_W-1:0][XLEN-1:0]      value;
   logic [RT_W-1:0]                valid;

   // Effective completion state of each window slot
   always_comb begin
      for (int k = 0; k < RT_W; k++) begin
         idx[k]   = head + ROB_TAG_W'(k);
         done[k]  = head_entries[k].complete;
         brn[k]   = head_entries[k].take_branch;
         value[k] = head_entries[k].value;
`ifdef ROB_CDB_BYPASS_EN
         for (int i = 0; i < RT_W; i++) begin
            if (cdb[i].valid && (cdb[i].tag == idx[k]) && (ROB_CNT_W'(k) < count)) begin
               done[k]  = 1'b1;
               brn[k]   = cdb[i].take_branch;
               value[k] = cdb[i].value;
            end
         end
`endif
      end
   end

   // In-order valid chain; a redirect or halt ends the window
   always_comb begin
      valid    = '0;
      valid[0] = (count != '0) && done[0];
      for (int k = 1; k < RT_W; k++) begin
         valid[k] = valid[k-1] && (ROB_CNT_W'(k) < count) && done[k]
                    && !(brn[k-1] || head_entries[k-1].halt);
      end
      pop_cnt = popcount3(valid);
      for (int k = 0; k < RT_W; k++) begin
         packets[k].dest_reg_idx = head_entries[k].dest_reg_idx;
         packets[k].tag          = idx[k];
         packets[k].value        = value[k];
         packets[k].valid        = valid[k];
         packets[k].take_branch  = brn[k];
         packets[k].halt         = head_entries[k].halt;
         packets[k].NPC          = head_entries[k].NPC;
      end
   end

endmodule

// File: rtl/rob.sv
// Reorder buffer for the 3-wide core: in-order allocate, CDB completion, in-order
// retire of up to three entries per cycle. Optional macro: ROB_CDB_BYPASS_EN.
module rob
   import rob_pkg::*;
(
   input  logic                                clock,
   input  logic                                reset,
   input  logic [RT_W-1:0]                     dp_valid,
   input  logic [RT_W-1:0][REG_IDX_W-1:0]      dp_dest_reg_idx,
   input  logic [RT_W-1:0][XLEN-1:0]           dp_NPC,
   input  logic [RT_W-1:0]                     dp_halt,
   output logic [RT_W-1:0][ROB_TAG_W-1:0]      dp_tag,
   output logic [1:0]                          free_slots,
   input  logic [RT_W-1:0]                     cdb_valid,
   input  logic [RT_W-1:0][ROB_TAG_W-1:0]      cdb_tag,
   input  logic [RT_W-1:0][XLEN-1:0]           cdb_value,
   input  logic [RT_W-1:0]                     cdb_take_branch,
   input  logic                                squash_flag,
   output ROB_RT_PACKET [RT_W-1:0]             rob_rt_packet_out,
   output logic                                rob_empty
);

   rob_entry_t                     entries [ROB_SZ];
   logic [ROB_TAG_W-1:0]           head;
   logic [ROB_TAG_W-1:0]           tail;
   logic [ROB_CNT_W-1:0]           count;

   logic [ROB_CNT_W-1:0]           empty_slots;
   logic [1:0]                     dp_req;
   logic [1:0]                     accepted;
   logic [1:0]                     pop_cnt;
   logic [RT_W-1:0][ROB_TAG_W-1:0] rd_idx;
   logic [RT_W-1:0][ROB_TAG_W-1:0] cdb_off;
   logic [RT_W-1:0]                cdb_live;
   rob_entry_t [RT_W-1:0]          head_entries;
   DP_ROB_PACKET [RT_W-1:0]        dp_pkt;
   CDB_PACKET [RT_W-1:0]           cdb_pkt;

   // Occupancy, allocation and tag generation
   always_comb begin
      empty_slots = ROB_CNT_W'(ROB_SZ) - count;
      free_slots  = (empty_slots >= ROB_CNT_W'(RT_W)) ? 2'(RT_W) : 2'(empty_slots);
      dp_req      = popcount3(dp_valid);
      accepted    = (dp_req > free_slots) ? free_slots : dp_req;
      rob_empty   = (count == '0);
      for (int i = 0; i < RT_W; i++) begin
         dp_tag[i]       = tail + ROB_TAG_W'(i);
         rd_idx[i]       = head + ROB_TAG_W'(i);
         head_entries[i] = entries[rd_idx[i]];

         dp_pkt[i].valid        = dp_valid[i] && (2'(i) < accepted);
         dp_pkt[i].dest_reg_idx = dp_dest_reg_idx[i];
         dp_pkt[i].NPC          = dp_NPC[i];
         dp_pkt[i].halt         = dp_halt[i];

         cdb_pkt[i].valid       = cdb_valid[i];
         cdb_pkt[i].tag         = cdb_tag[i];
         cdb_pkt[i].value       = cdb_value[i];
         cdb_pkt[i].take_branch = cdb_take_branch[i];

         // Distance from head decides whether a CDB tag names a live entry
         cdb_off[i]  = cdb_tag[i] - head;
         cdb_live[i] = ({1'b0, cdb_off[i]} < count);
      end
   end

   rob_retire_window u_window (
      .head         (head),
      .count        (count),
      .head_entries (head_entries),
`ifdef ROB_CDB_BYPASS_EN
      .cdb          (cdb_pkt),
`endif
      .packets      (rob_rt_packet_out),
      .pop_cnt      (pop_cnt)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int e = 0; e < ROB_SZ; e++) entries[e] <= '0;
      end else if (squash_flag) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int e = 0; e < ROB_SZ; e++) entries[e].complete <= 1'b0;
      end else begin
         for (int i = 0; i < RT_W; i++) begin
            if (cdb_pkt[i].valid && cdb_live[i]) begin
               entries[cdb_pkt[i].tag].complete    <= 1'b1;
               entries[cdb_pkt[i].tag].value       <= cdb_pkt[i].value;
               entries[cdb_pkt[i].tag].take_branch <= cdb_pkt[i].take_branch;
            end
         end
         // Dispatch only touches free entries, so it never collides with a CDB write
         for (int i = 0; i < RT_W; i++) begin
            if (dp_pkt[i].valid) begin
               entries[dp_tag[i]].dest_reg_idx <= dp_pkt[i].dest_reg_idx;
               entries[dp_tag[i]].NPC          <= dp_pkt[i].NPC;
               entries[dp_tag[i]].halt         <= dp_pkt[i].halt;
               entries[dp_tag[i]].value        <= '0;
               entries[dp_tag[i]].take_branch  <= 1'b0;
               entries[dp_tag[i]].complete     <= 1'b0;
            end
         end
         head  <= head + ROB_TAG_W'(pop_cnt);
         tail  <= tail + ROB_TAG_W'(accepted);
         count <= count - ROB_CNT_W'(pop_cnt) + ROB_CNT_W'(accepted);
      end
   end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios plus randomized traffic,
// compared every cycle against a queue-of-entries reference model.
module tb_rob;
   import rob_pkg::*;

   logic                           clock = 1'b0;
   logic                           reset;
   logic [2:0]                     dp_valid;
   logic [2:0][4:0]                dp_dest_reg_idx;
   logic [2:0][31:0]               dp_NPC;
   logic [2:0]                     dp_halt;
   logic [2:0][4:0]                dp_tag;
   logic [1:0]                     free_slots;
   logic [2:0]                     cdb_valid;
   logic [2:0][4:0]                cdb_tag;
   logic [2:0][31:0]               cdb_value;
   logic [2:0]                     cdb_take_branch;
   logic                           squash_flag;
   ROB_RT_PACKET [2:0]             rob_rt_packet_out;
   logic                           rob_empty;

   always #5 clock = ~clock;

   rob dut (
      .clock             (clock),
      .reset             (reset),
      .dp_valid          (dp_valid),
      .dp_dest_reg_idx   (dp_dest_reg_idx),
      .dp_NPC            (dp_NPC),
      .dp_halt           (dp_halt),
      .dp_tag            (dp_tag),
      .free_slots        (free_slots),
      .cdb_valid         (cdb_valid),
      .cdb_tag           (cdb_tag),
      .cdb_value         (cdb_value),
      .cdb_take_branch   (cdb_take_branch),
      .squash_flag       (squash_flag),
      .rob_rt_packet_out (rob_rt_packet_out),
      .rob_empty         (rob_empty)
   );

   int n_checks = 0;
   int n_fails  = 0;
   bit checks_on = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: circular buffer of entries plus head/tail/count integers
   logic [4:0]  m_dest [32];
   logic [31:0] m_npc  [32];
   logic [31:0] m_val  [32];
   bit          m_halt [32];
   bit          m_tb   [32];
   bit          m_cmp  [32];
   int          m_head, m_tail, m_count;
   bit          e_valid [3];
   logic [31:0] e_val   [3];
   bit          e_tb    [3];
   int          e_pop;

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic compute_expect();
      bit open;
      open  = 1;
      e_pop = 0;
      for (int k = 0; k < 3; k++) begin
         int idx;
         bit cmp;
         idx      = (m_head + k) % 32;
         cmp      = m_cmp[idx];
         e_val[k] = m_val[idx];
         e_tb[k]  = m_tb[idx];
`ifdef ROB_CDB_BYPASS_EN
         if (k < m_count)
            for (int i = 0; i < 3; i++)
               if (cdb_valid[i] && int'(cdb_tag[i]) == idx) begin
                  cmp      = 1;
                  e_val[k] = cdb_value[i];
                  e_tb[k]  = cdb_take_branch[i];
               end
`endif
         e_valid[k] = open && (k < m_count) && cmp;
         if (!e_valid[k]) open = 0;
         else begin
            e_pop++;
            if (e_tb[k] || m_halt[idx]) open = 0;
         end
      end
   endtask

   task automatic check_outputs();
      ROB_RT_PACKET p;
      check_eq("free_slots", free_slots, min_int(3, 32 - m_count));
      check_eq("rob_empty", rob_empty, (m_count == 0));
      for (int i = 0; i < 3; i++)
         check_eq($sformatf("dp_tag%0d", i), dp_tag[i], (m_tail + i) % 32);
      for (int k = 0; k < 3; k++) begin
         int idx;
         idx = (m_head + k) % 32;
         p   = rob_rt_packet_out[k];
         check_eq($sformatf("pkt%0d.valid", k), p.valid, e_valid[k]);
         check_eq($sformatf("pkt%0d.tag", k), p.tag, idx);
         check_eq($sformatf("pkt%0d.dest", k), p.dest_reg_idx, m_dest[idx]);
         check_eq($sformatf("pkt%0d.value", k), p.value, e_val[k]);
         check_eq($sformatf("pkt%0d.take_branch", k), p.take_branch, e_tb[k]);
         check_eq($sformatf("pkt%0d.halt", k), p.halt, m_halt[idx]);
         check_eq($sformatf("pkt%0d.NPC", k), p.NPC, m_npc[idx]);
      end
   endtask

   task automatic model_update();
      if (!reset) begin
         m_head = 0; m_tail = 0; m_count = 0;
         for (int e = 0; e < 32; e++) begin
            m_dest[e] = '0; m_npc[e] = '0; m_val[e] = '0;
            m_halt[e] = 0;  m_tb[e]  = 0;  m_cmp[e] = 0;
         end
      end else if (squash_flag) begin
         m_head = 0; m_tail = 0; m_count = 0;
         for (int e = 0; e < 32; e++) m_cmp[e] = 0;
      end else begin
         int acc;
         acc = min_int($countones(dp_valid), min_int(3, 32 - m_count));
         for (int i = 0; i < 3; i++) begin
            int t;
            t = int'(cdb_tag[i]);
            if (cdb_valid[i] && ((t - m_head + 32) % 32) < m_count) begin
               m_cmp[t] = 1;
               m_val[t] = cdb_value[i];
               m_tb[t]  = cdb_take_branch[i];
            end
         end
         for (int i = 0; i < acc; i++) begin
            int idx;
            idx = (m_tail + i) % 32;
            m_dest[idx] = dp_dest_reg_idx[i];
            m_npc[idx]  = dp_NPC[i];
            m_halt[idx] = dp_halt[i];
            m_val[idx]  = '0;
            m_tb[idx]   = 0;
            m_cmp[idx]  = 0;
         end
         m_head  = (m_head + e_pop) % 32;
         m_tail  = (m_tail + acc) % 32;
         m_count = m_count + acc - e_pop;
      end
   endtask

   task automatic set_idle();
      reset = 1'b1; squash_flag = 1'b0;
      dp_valid = '0; dp_dest_reg_idx = '0; dp_NPC = '0; dp_halt = '0;
      cdb_valid = '0; cdb_tag = '0; cdb_value = '0; cdb_take_branch = '0;
   endtask

   task automatic set_dp(input int s, input logic [4:0] d, input logic [31:0] npc, input bit h);
      dp_valid[s] = 1'b1; dp_dest_reg_idx[s] = d; dp_NPC[s] = npc; dp_halt[s] = h;
   endtask

   task automatic set_cdb(input int s, input int t, input logic [31:0] v, input bit b);
      cdb_valid[s] = 1'b1; cdb_tag[s] = 5'(t); cdb_value[s] = v; cdb_take_branch[s] = b;
   endtask

   task automatic dp3(input int base);
      for (int s = 0; s < 3; s++) set_dp(s, 5'(base + s), 32'(4 * (base + s) + 4), 1'b0);
   endtask

   // One clock: check combinational outputs, advance model at the edge
   task automatic tick();
      #1;
      compute_expect();
      if (checks_on) check_outputs();
      @(posedge clock);
      model_update();
      @(negedge clock);
      set_idle();
   endtask

   function automatic logic [2:0] valids();
      return {rob_rt_packet_out[2].valid, rob_rt_packet_out[1].valid, rob_rt_packet_out[0].valid};
   endfunction

   initial begin
      set_idle();
      reset = 1'b0; tick();
      checks_on = 1;
      reset = 1'b0; tick();
      #1;
      check_eq("reset.dp_tag", dp_tag, {5'd2, 5'd1, 5'd0});

      // Basic dispatch, complete, retire
      set_dp(0, 5'd1, 32'h4, 0); set_dp(1, 5'd2, 32'h8, 0); set_dp(2, 5'd3, 32'hc, 0); tick();
      set_cdb(0, 0, 32'd10, 0); set_cdb(1, 1, 32'd20, 0); set_cdb(2, 2, 32'd30, 0); tick();
      #1;
      check_eq("basic.valids", valids(), 3'b111);
      check_eq("basic.val1", rob_rt_packet_out[1].value, 32'd20);
      tick();
      #1;
      check_eq("basic.empty", rob_empty, 1'b1);

      // Taken branch closes the window, then squash discards same-cycle dispatch
      squash_flag = 1'b1; tick();
      dp3(4); tick();
      set_cdb(0, 0, 32'h100, 1); set_cdb(1, 1, 32'd1, 0); set_cdb(2, 2, 32'd2, 0); tick();
      #1;
      check_eq("branch.valids", valids(), 3'b001);
      check_eq("branch.val0", rob_rt_packet_out[0].value, 32'h100);
      squash_flag = 1'b1; dp3(7); tick();
      #1;
      check_eq("squash.empty", rob_empty, 1'b1);
      check_eq("squash.tail", dp_tag[0], 5'd0);
      check_eq("squash.free", free_slots, 2'd3);

      // Incomplete head blocks younger completed entries
      dp3(10); tick();
      set_cdb(0, 1, 32'd11, 0); set_cdb(1, 2, 32'd12, 0); tick();
      #1;
      check_eq("order.valids", valids(), 3'b000);
      set_cdb(0, 0, 32'd13, 0); tick();
      #1;
      check_eq("order.valids2", valids(), 3'b111);
      tick();

      // Halt in slot 1 closes the window after it
      squash_flag = 1'b1; tick();
      set_dp(0, 5'd1, 32'h10, 0); set_dp(1, 5'd2, 32'h14, 1); set_dp(2, 5'd3, 32'h18, 0); tick();
      set_cdb(0, 0, 32'd1, 0); set_cdb(1, 1, 32'd2, 0); set_cdb(2, 2, 32'd3, 0); tick();
      #1;
      check_eq("halt.valids", valids(), 3'b011);
      tick();
      #1;
      check_eq("halt.left_tag", rob_rt_packet_out[0].tag, 5'd2);
      check_eq("halt.left_valid", rob_rt_packet_out[0].valid, 1'b1);
      tick();

      // Fill to capacity; excess dispatch is dropped
      squash_flag = 1'b1; tick();
      for (int j = 0; j < 10; j++) begin dp3(j * 3); tick(); end
      dp3(30); tick();
      #1;
      check_eq("full.free", free_slots, 2'd0);
      dp3(1); tick();
      #1;
      check_eq("full.tail", dp_tag[0], 5'd0);
      check_eq("full.free2", free_slots, 2'd0);

      // Wrap-around retire across entry 31 -> 0
      squash_flag = 1'b1; tick();
      for (int j = 0; j < 10; j++) begin dp3(j); tick(); end
      for (int j = 0; j < 10; j++) begin
         for (int s = 0; s < 3; s++) set_cdb(s, 3 * j + s, 32'(100 + 3 * j + s), 0);
         tick();
      end
      for (int n = 0; n < 16 && m_count != 0; n++) tick();
      check_eq("wrap.drained", rob_empty, 1'b1);
      dp3(20); tick();
      set_dp(0, 5'd9, 32'h200, 0); tick();
      set_cdb(0, 30, 32'd30, 0); set_cdb(1, 31, 32'd31, 0); set_cdb(2, 0, 32'd32, 0); tick();
      set_cdb(0, 1, 32'd33, 0);
      #1;
      check_eq("wrap.valids", valids(), 3'b111);
      check_eq("wrap.tag0", rob_rt_packet_out[0].tag, 5'd30);
      check_eq("wrap.tag1", rob_rt_packet_out[1].tag, 5'd31);
      check_eq("wrap.tag2", rob_rt_packet_out[2].tag, 5'd0);
      tick();
      #1;
      check_eq("wrap.next_valids", valids(), 3'b001);
      check_eq("wrap.next_tag", rob_rt_packet_out[0].tag, 5'd1);
      tick();

      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         int n;
         n = int'($urandom % 4);
         for (int s = 0; s < n; s++)
            set_dp(s, 5'($urandom), $urandom, ($urandom % 8) == 0);
         for (int s = 0; s < 3; s++) begin
            if (($urandom % 10) < 6) begin
               int t;
               if (m_count > 0 && ($urandom % 10) < 8) t = (m_head + int'($urandom % m_count)) % 32;
               else t = int'($urandom % 32);
               set_cdb(s, t, $urandom, ($urandom % 6) == 0);
            end
         end
         squash_flag = (($urandom % 40) == 0);
         reset       = !(($urandom % 150) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
